// File: rtl/nios_system_sensor_poller.sv
// Avalon-MM read master that periodically polls a sensor PIO data register,
// shadows the low DATA_W bits and flags arrival, change and read timeout.
module nios_system_sensor_poller #(
   parameter int unsigned DATA_W   = 9,
   parameter int unsigned POLL_DIV = 50000,
   parameter int unsigned TIMEOUT  = 255
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              enable,
   output logic [1:0]        avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   output logic [DATA_W-1:0] sample,
   output logic              sample_valid,
   output logic              changed,
   output logic              timeout_err
);

   localparam int unsigned PollW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int unsigned TmoW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [PollW-1:0] PollLast = PollW'(POLL_DIV - 1);
   localparam logic [TmoW-1:0]  TmoLast  = TmoW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      StIdle,
      StReq,
      StWait
   } state_e;

   state_e              state_q, state_d;
   logic [PollW-1:0]    poll_cnt_q, poll_cnt_d;
   logic [TmoW-1:0]     tmo_cnt_q, tmo_cnt_d;
   logic                read_q, read_d;
   logic [DATA_W-1:0]   sample_q, sample_d;
   logic                valid_q, valid_d;
   logic                changed_q, changed_d;
   logic                err_q, err_d;

   logic                tick;
   logic                capture;
   logic                abort;
   logic                tmo_last;
   logic [DATA_W-1:0]   rd_field;
   logic                unused_rdata;

   // Only the low DATA_W bits carry the sensor field.
   assign rd_field     = avm_readdata[DATA_W-1:0];
   assign unused_rdata = ^avm_readdata;

   // Free-running poll divider, parked at zero while polling is disabled.
   always_comb begin
      poll_cnt_d = '0;
      if (enable) begin
         poll_cnt_d = (poll_cnt_q == PollLast) ? '0 : poll_cnt_q + PollW'(1);
      end
   end

   assign tick     = enable && (poll_cnt_q == PollLast);
   assign tmo_last = (tmo_cnt_q == TmoLast);

   always_comb begin
      state_d   = state_q;
      tmo_cnt_d = tmo_cnt_q;
      read_d    = read_q;
      capture   = 1'b0;
      abort     = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (tick) begin
               state_d   = StReq;
               read_d    = 1'b1;
               tmo_cnt_d = '0;
            end
         end
         StReq: begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            // A response in the accept cycle wins over a coincident timeout.
            if (!avm_waitrequest && avm_readdatavalid) begin
               capture = 1'b1;
            end else if (tmo_last) begin
               abort = 1'b1;
            end else if (!avm_waitrequest) begin
               state_d = StWait;
               read_d  = 1'b0;
            end
         end
         StWait: begin
            tmo_cnt_d = tmo_cnt_q + TmoW'(1);
            if (avm_readdatavalid) begin
               capture = 1'b1;
            end else if (tmo_last) begin
               abort = 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            read_d  = 1'b0;
         end
      endcase

      if (capture || abort) begin
         state_d = StIdle;
         read_d  = 1'b0;
      end
   end

   always_comb begin
      sample_d  = sample_q;
      valid_d   = 1'b0;
      changed_d = 1'b0;
      err_d     = err_q;
      if (capture) begin
         sample_d  = rd_field;
         valid_d   = 1'b1;
         changed_d = (rd_field != sample_q);
         err_d     = 1'b0;
      end else if (abort) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         poll_cnt_q <= '0;
         tmo_cnt_q  <= '0;
         read_q     <= 1'b0;
         sample_q   <= '0;
         valid_q    <= 1'b0;
         changed_q  <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         poll_cnt_q <= poll_cnt_d;
         tmo_cnt_q  <= tmo_cnt_d;
         read_q     <= read_d;
         sample_q   <= sample_d;
         valid_q    <= valid_d;
         changed_q  <= changed_d;
         err_q      <= err_d;
      end
   end

   assign avm_address  = 2'b00;
   assign avm_read     = read_q;
   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign changed      = changed_q;
   assign timeout_err  = err_q;

endmodule

// File: tb/tb_nios_system_sensor_poller.sv
// Randomised bench for nios_system_sensor_poller: a behavioural Avalon slave plus a
// transaction-level model of the expected sample, change and timeout outcomes.
module tb_nios_system_sensor_poller;

   localparam int unsigned DW = 9;
   localparam int unsigned PD = 8;
   localparam int unsigned TO = 16;

   logic          clk;
   logic          reset_n;
   logic          enable;
   logic [1:0]    avm_address;
   logic          avm_read;
   logic          avm_waitrequest;
   logic [31:0]   avm_readdata;
   logic          avm_readdatavalid;
   logic [DW-1:0] sample;
   logic          sample_valid;
   logic          changed;
   logic          timeout_err;

   int            cyc = 0;
   int            n_vec = 0;
   int            n_err = 0;

   int            cfg_ws = 0;
   int            cfg_lat = 1;
   logic [31:0]   cfg_data = '0;
   bit            cfg_norsp = 1'b0;

   logic [DW-1:0] model_sample;

   nios_system_sensor_poller #(
      .DATA_W  (DW),
      .POLL_DIV(PD),
      .TIMEOUT (TO)
   ) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .enable           (enable),
      .avm_address      (avm_address),
      .avm_read         (avm_read),
      .avm_waitrequest  (avm_waitrequest),
      .avm_readdata     (avm_readdata),
      .avm_readdatavalid(avm_readdatavalid),
      .sample           (sample),
      .sample_valid     (sample_valid),
      .changed          (changed),
      .timeout_err      (timeout_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Slave: cfg_ws stall cycles, then data cfg_lat cycles after acceptance (0 = same cycle).
   initial begin
      int wcnt;
      int pend;
      logic [31:0] pdata;
      wcnt = 0;
      pend = 0;
      pdata = '0;
      avm_waitrequest = 1'b0;
      avm_readdatavalid = 1'b0;
      avm_readdata = '0;
      forever begin
         @(posedge clk);
         #1;
         avm_readdatavalid = 1'b0;
         avm_readdata = $urandom;
         if (!reset_n) begin
            pend = 0;
            wcnt = 0;
            avm_waitrequest = 1'b0;
         end else begin
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata = pdata;
               end
            end
            if (avm_read) begin
               if (wcnt < cfg_ws) begin
                  avm_waitrequest = 1'b1;
                  wcnt++;
               end else begin
                  avm_waitrequest = 1'b0;
                  wcnt = 0;
                  if (!cfg_norsp) begin
                     if (cfg_lat == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata = cfg_data;
                     end else begin
                        pend = cfg_lat;
                        pdata = cfg_data;
                     end
                  end
               end
            end else begin
               avm_waitrequest = 1'b0;
               wcnt = 0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Follows one poll from its read rise to capture or timeout; called at a negedge.
   task automatic observe_poll(output bit ok, output int rise_t, output int hi,
                               output bit sv, output logic [DW-1:0] smp, output bit chg,
                               output bit err, output bit after);
      int g;
      ok = 1'b0; rise_t = 0; hi = 0; sv = 1'b0; smp = '0; chg = 1'b0; err = 1'b0;
      after = 1'b0; g = 0;
      while (!avm_read && g < 4 * PD) begin
         @(negedge clk);
         g++;
      end
      if (!avm_read) return;
      ok = 1'b1;
      rise_t = cyc;
      while (avm_read && hi < 2 * TO) begin
         hi++;
         @(negedge clk);
      end
      while (!sample_valid && (cyc - rise_t) < TO) @(negedge clk);
      sv = sample_valid;
      smp = sample;
      chg = changed;
      err = timeout_err;
      if (sv) begin
         @(negedge clk);
         after = sample_valid;
      end
   endtask

   task automatic count_to_rise(output int n);
      n = 0;
      while (!avm_read && n < 4 * PD) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      int rises;
      reset_n = 1'b0;
      enable = 1'b0;
      model_sample = '0;
      repeat (2) @(negedge clk);
      n_vec++;
      if ({avm_read, sample_valid, changed, timeout_err} !== 4'b0000) begin
         n_err++;
         $display("FAIL reset_flags: got %b want 0000",
                  {avm_read, sample_valid, changed, timeout_err});
      end
      n_vec++;
      if (sample !== '0) begin
         n_err++;
         $display("FAIL reset_sample: got %h want 0", sample);
      end
      n_vec++;
      if (avm_address !== 2'b00) begin
         n_err++;
         $display("FAIL reset_address: got %b want 00", avm_address);
      end
      reset_n = 1'b1;
      rises = 0;
      repeat (3 * PD) begin
         @(negedge clk);
         if (avm_read) rises++;
      end
      n_vec++;
      if (rises !== 0) begin
         n_err++;
         $display("FAIL disabled_no_read: got %0d read cycles want 0", rises);
      end
   endtask

   task automatic test_basic();
      int n, rise, prev, hi;
      bit ok, sv, chg, err, after;
      logic [DW-1:0] smp, exp_s;
      bit exp_c;
      cfg_ws = 0; cfg_lat = 1; cfg_norsp = 1'b0; cfg_data = 32'h0000_01A5;
      enable = 1'b1;
      count_to_rise(n);
      n_vec++;
      if (n !== PD) begin
         n_err++;
         $display("FAIL basic_first_poll: got %0d cycles want %0d", n, PD);
      end
      prev = -1;
      for (int p = 0; p < 3; p++) begin
         exp_s = cfg_data[DW-1:0];
         exp_c = (exp_s != model_sample);
         observe_poll(ok, rise, hi, sv, smp, chg, err, after);
         n_vec++;
         if (!ok || hi !== 1 || !sv || after) begin
            n_err++;
            $display("FAIL basic_handshake[%0d]: ok=%0d hi=%0d sv=%0d after=%0d want 1 1 1 0",
                     p, ok, hi, sv, after);
         end
         n_vec++;
         if (smp !== exp_s || chg !== exp_c) begin
            n_err++;
            $display("FAIL basic_data[%0d]: got %h/%0d want %h/%0d", p, smp, chg, exp_s, exp_c);
         end
         if (prev >= 0) begin
            n_vec++;
            if (rise - prev !== PD) begin
               n_err++;
               $display("FAIL basic_period[%0d]: got %0d want %0d", p, rise - prev, PD);
            end
         end
         prev = rise;
         model_sample = exp_s;
      end
   endtask

   task automatic test_waitstates();
      int rise, hi;
      bit ok, sv, chg, err, after;
      logic [DW-1:0] smp;
      cfg_ws = 3; cfg_lat = 1; cfg_data = 32'h0000_00FF;
      observe_poll(ok, rise, hi, sv, smp, chg, err, after);
      n_vec++;
      if (!ok || hi !== 4) begin
         n_err++;
         $display("FAIL ws_read_len: got %0d want 4", hi);
      end
      n_vec++;
      if (!sv || smp !== 9'h0FF || !chg || err) begin
         n_err++;
         $display("FAIL ws_data: got sv=%0d %h chg=%0d err=%0d want 1 0ff 1 0",
                  sv, smp, chg, err);
      end
      model_sample = 9'h0FF;
   endtask

   task automatic test_timeout();
      int rise, prev, hi;
      bit ok, sv, chg, err, after;
      logic [DW-1:0] smp;
      // Slave stalls forever: the request itself times out.
      cfg_ws = 100000; cfg_lat = 1;
      observe_poll(ok, rise, hi, sv, smp, chg, err, after);
      n_vec++;
      if (!ok || hi !== TO || sv || !err) begin
         n_err++;
         $display("FAIL tmo_req: hi=%0d sv=%0d err=%0d want %0d 0 1", hi, sv, err, TO);
      end
      n_vec++;
      if (sample !== model_sample) begin
         n_err++;
         $display("FAIL tmo_req_sample: got %h want %h", sample, model_sample);
      end
      prev = rise;
      // Request accepted but no data ever returned.
      cfg_ws = 0; cfg_norsp = 1'b1;
      observe_poll(ok, rise, hi, sv, smp, chg, err, after);
      n_vec++;
      if (!ok || hi !== 1 || sv || !err || sample !== model_sample) begin
         n_err++;
         $display("FAIL tmo_wait: hi=%0d sv=%0d err=%0d smp=%h want 1 0 1 %h",
                  hi, sv, err, sample, model_sample);
      end
      n_vec++;
      if (rise - prev !== 3 * PD) begin
         n_err++;
         $display("FAIL tmo_tick_dropped: got %0d want %0d", rise - prev, 3 * PD);
      end
      prev = rise;
      cfg_norsp = 1'b0; cfg_lat = 1; cfg_data = 32'h0000_0003;
      observe_poll(ok, rise, hi, sv, smp, chg, err, after);
      n_vec++;
      if (!sv || smp !== 9'h003 || !chg || err) begin
         n_err++;
         $display("FAIL tmo_recover: sv=%0d %h chg=%0d err=%0d want 1 003 1 0", sv, smp, chg, err);
      end
      n_vec++;
      if (rise - prev !== 3 * PD) begin
         n_err++;
         $display("FAIL tmo_wait_period: got %0d want %0d", rise - prev, 3 * PD);
      end
      model_sample = 9'h003;
   endtask

   task automatic test_reset_mid();
      int n;
      cfg_ws = 5; cfg_lat = 1; cfg_data = 32'h0000_0111;
      count_to_rise(n);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      n_vec++;
      if (avm_read !== 1'b0) begin
         n_err++;
         $display("FAIL rstmid_read: got %b want 0", avm_read);
      end
      n_vec++;
      if (sample !== '0 || {sample_valid, changed, timeout_err} !== 3'b000) begin
         n_err++;
         $display("FAIL rstmid_outputs: got %h %b want 000 000", sample,
                  {sample_valid, changed, timeout_err});
      end
      model_sample = '0;
      repeat (2) @(negedge clk);
      // The resumed poll returns a word whose sensor field is zero.
      cfg_ws = 0; cfg_lat = 1; cfg_data = 32'hFFFF_FE00;
      reset_n = 1'b1;
      count_to_rise(n);
      n_vec++;
      if (n !== PD) begin
         n_err++;
         $display("FAIL rstmid_resume: got %0d cycles want %0d", n, PD);
      end
   endtask

   task automatic test_high_bits();
      int rise, hi;
      bit ok, sv, chg, err, after;
      logic [DW-1:0] smp;
      observe_poll(ok, rise, hi, sv, smp, chg, err, after);
      n_vec++;
      if (!ok || !sv || smp !== '0 || chg !== 1'b0) begin
         n_err++;
         $display("FAIL high_bits: sv=%0d smp=%h chg=%0d want 1 000 0", sv, smp, chg);
      end
   endtask

   task automatic test_enable_drop();
      int n, g, rises;
      cfg_ws = 0; cfg_lat = 10; cfg_data = 32'h0000_0155;
      count_to_rise(n);
      @(negedge clk);
      enable = 1'b0;
      g = 0;
      while (!sample_valid && g < TO + 4) begin
         @(negedge clk);
         g++;
      end
      n_vec++;
      if (!sample_valid || sample !== 9'h155 || !changed || timeout_err) begin
         n_err++;
         $display("FAIL endrop_complete: sv=%0d %h chg=%0d err=%0d want 1 155 1 0",
                  sample_valid, sample, changed, timeout_err);
      end
      model_sample = 9'h155;
      rises = 0;
      repeat (3 * PD) begin
         @(negedge clk);
         if (avm_read) rises++;
      end
      n_vec++;
      if (rises !== 0) begin
         n_err++;
         $display("FAIL endrop_quiet: got %0d read cycles want 0", rises);
      end
   endtask

   task automatic test_late_rdv();
      int n, rise, hi;
      bit ok, sv, chg, err, after, sv_seen, rd_seen;
      logic [DW-1:0] smp;
      cfg_ws = 0; cfg_lat = 20; cfg_data = 32'h0000_00AA;
      enable = 1'b1;
      count_to_rise(n);
      n_vec++;
      if (n !== PD) begin
         n_err++;
         $display("FAIL late_restart: got %0d cycles want %0d", n, PD);
      end
      @(negedge clk);
      enable = 1'b0;
      sv_seen = 1'b0;
      rd_seen = 1'b0;
      repeat (24) begin
         @(negedge clk);
         sv_seen |= sample_valid;
         rd_seen |= avm_read;
      end
      n_vec++;
      if (sv_seen || rd_seen || !timeout_err || sample !== model_sample) begin
         n_err++;
         $display("FAIL late_ignored: sv=%0d rd=%0d err=%0d smp=%h want 0 0 1 %h",
                  sv_seen, rd_seen, timeout_err, sample, model_sample);
      end
      cfg_lat = 1;
      enable = 1'b1;
      observe_poll(ok, rise, hi, sv, smp, chg, err, after);
      n_vec++;
      if (!sv || smp !== 9'h0AA || !chg || err) begin
         n_err++;
         $display("FAIL late_recover: sv=%0d %h chg=%0d err=%0d want 1 0aa 1 0", sv, smp, chg, err);
      end
      model_sample = 9'h0AA;
   endtask

   task automatic test_random();
      int rise, prev, hi, ws, lat;
      bit ok, sv, chg, err, after;
      logic [DW-1:0] smp, exp_s;
      logic [31:0] d;
      bit exp_c;
      prev = -1;
      for (int i = 0; i < 24; i++) begin
         ws = $urandom_range(0, 3);
         lat = $urandom_range(0, 2);
         d = $urandom;
         if (i % 4 == 3) d[DW-1:0] = model_sample;
         cfg_ws = ws; cfg_lat = lat; cfg_data = d;
         exp_s = d[DW-1:0];
         exp_c = (exp_s != model_sample);
         observe_poll(ok, rise, hi, sv, smp, chg, err, after);
         n_vec++;
         if (!ok || hi !== ws + 1 || !sv || after || err) begin
            n_err++;
            $display("FAIL rand_handshake[%0d]: hi=%0d sv=%0d after=%0d err=%0d want %0d 1 0 0",
                     i, hi, sv, after, err, ws + 1);
         end
         n_vec++;
         if (smp !== exp_s || chg !== exp_c) begin
            n_err++;
            $display("FAIL rand_data[%0d]: got %h/%0d want %h/%0d", i, smp, chg, exp_s, exp_c);
         end
         if (prev >= 0) begin
            n_vec++;
            if (rise - prev !== PD) begin
               n_err++;
               $display("FAIL rand_period[%0d]: got %0d want %0d", i, rise - prev, PD);
            end
         end
         prev = rise;
         model_sample = exp_s;
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_waitstates();
      test_timeout();
      test_reset_mid();
      test_high_bits();
      test_enable_drop();
      test_late_rdv();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
